// File: rtl/zx_sdrive_mixer.sv
// Soundrive-style multi-channel DAC on the ZX bus.
// Per-channel/covox port decode, beeper/tape fold-in, L/R mix, 1-bit sigma-delta.
module zx_sdrive_mixer #(
  parameter int          CHANNELS   = 4,
  parameter int          DATA_W     = 8,
  parameter int          STEREO     = 1,
  parameter logic [7:0]  PORT_CH0   = 8'h0F,
  parameter logic [7:0]  PORT_CH1   = 8'h1F,
  parameter logic [7:0]  PORT_CH2   = 8'h4F,
  parameter logic [7:0]  PORT_CH3   = 8'h5F,
  parameter logic [7:0]  PORT_COVOX = 8'hFB,
  parameter logic [7:0]  BEEP_LVL   = 8'h40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] d,
  input  logic       n_wr,
  input  logic       n_m1,
  input  logic       n_iorq,
  output logic       n_iorqge,
  output logic       dac_l,
  output logic       dac_r
);

  localparam int SUM_W = DATA_W + 2;
  localparam logic [15:0] SMAX = 16'((1 << SUM_W) - 1);

  logic              r_s1_wr;
  logic              r_s2_wr;
  logic [7:0]        r_s1_a;
  logic [7:0]        r_s1_d;
  logic [DATA_W-1:0] r_ch [4];
  logic              r_beep;
  logic              r_tape;
  logic [SUM_W-1:0]  r_sum_l;
  logic [SUM_W-1:0]  r_sum_r;
  logic [SUM_W:0]    r_acc_l;
  logic [SUM_W:0]    r_acc_r;
  logic              r_ge;

  logic              w_commit;
  logic [3:0]        w_sel;
  logic              w_cov;
  logic [DATA_W-1:0] w_chv [4];
  logic [15:0]       w_extra;
  logic [15:0]       w_lo;
  logic [15:0]       w_hi;
  logic [15:0]       w_raw_l;
  logic [15:0]       w_raw_r;
  logic [SUM_W-1:0]  w_sat_l;
  logic [SUM_W-1:0]  w_sat_r;

  // channel ports that exist in this build
  function automatic logic [3:0] f_sel(input logic [7:0] ad);
    logic [3:0] s;
    s = {ad == PORT_CH3, ad == PORT_CH2,
         ad == PORT_CH1, ad == PORT_CH0};
    for (int i = 0; i < 4; i++)
      if (i >= CHANNELS) s[i] = 1'b0;
    return s;
  endfunction

  assign w_commit = r_s1_wr & ~r_s2_wr;
  assign w_sel    = f_sel(r_s1_a);
  assign w_cov    = (r_s1_a == PORT_COVOX);

  // write strobe edge pipeline: one commit per I/O write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_wr <= 1'b0;
      r_s2_wr <= 1'b0;
      r_s1_a  <= '0;
      r_s1_d  <= '0;
    end else begin
      r_s1_wr <= ~n_iorq & n_m1 & ~n_wr;
      r_s2_wr <= r_s1_wr;
      r_s1_a  <= a;
      r_s1_d  <= d;
    end
  end

  // channel, beeper and tape registers loaded on commit
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_ch[i] <= '0;
      r_beep <= 1'b0;
      r_tape <= 1'b0;
    end else if (w_commit) begin
      for (int i = 0; i < 4; i++)
        if (i < CHANNELS && (w_sel[i] || w_cov))
          r_ch[i] <= r_s1_d[DATA_W-1:0];
      if (!r_s1_a[0]) begin
        r_beep <= r_s1_d[4];
        r_tape <= r_s1_d[3];
      end
    end
  end

  // mix channels plus beeper/tape level, clamp at full scale
  always_comb begin
    for (int i = 0; i < 4; i++)
      w_chv[i] = (i < CHANNELS) ? r_ch[i] : '0;
    w_extra = (r_beep ? 16'(BEEP_LVL) : 16'd0)
            + (r_tape ? 16'(BEEP_LVL >> 1) : 16'd0);
    w_lo = 16'(w_chv[0]) + 16'(w_chv[1]);
    w_hi = 16'(w_chv[2]) + 16'(w_chv[3]);
    if (STEREO != 0) begin
      w_raw_l = w_lo + w_extra;
      w_raw_r = w_hi + w_extra;
    end else begin
      w_raw_l = w_lo + w_hi + w_extra;
      w_raw_r = w_raw_l;
    end
    w_sat_l = (w_raw_l > SMAX) ? SMAX[SUM_W-1:0]
                               : w_raw_l[SUM_W-1:0];
    w_sat_r = (w_raw_r > SMAX) ? SMAX[SUM_W-1:0]
                               : w_raw_r[SUM_W-1:0];
  end

  // registered mix sums and first-order sigma-delta accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum_l <= '0;
      r_sum_r <= '0;
      r_acc_l <= '0;
      r_acc_r <= '0;
    end else begin
      r_sum_l <= w_sat_l;
      r_sum_r <= w_sat_r;
      r_acc_l <= {1'b0, r_acc_l[SUM_W-1:0]} + {1'b0, r_sum_l};
      r_acc_r <= {1'b0, r_acc_r[SUM_W-1:0]} + {1'b0, r_sum_r};
    end
  end

  // claim the bus for every owned port, regardless of /IORQ
  always_ff @(posedge clk) begin
    if (rst) r_ge <= 1'b0;
    else     r_ge <= (|f_sel(a)) | (a == PORT_COVOX);
  end

  assign dac_l    = r_acc_l[SUM_W];
  assign dac_r    = r_acc_r[SUM_W];
  assign n_iorqge = r_ge ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_zx_sdrive_mixer.sv
// Bench for zx_sdrive_mixer: three builds share one Z80 bus.
// Ones density of each bitstream is checked against a sum model.
module tb_zx_sdrive_mixer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a;
  logic [7:0] d;
  logic       n_wr;
  logic       n_m1;
  logic       n_iorq;

  wire ge_st;
  wire ge_m2;
  wire ge_m4;
  pulldown (ge_st);
  pulldown (ge_m2);
  pulldown (ge_m4);

  wire st_l, st_r, m2_l, m2_r, m4_l, m4_r;

  int tests = 0;
  int fails = 0;
  int cnt [6];
  int m_ch [4];
  int m_beep;
  int m_tape;

  always #5 clk = ~clk;

  zx_sdrive_mixer u_st (
    .clk(clk), .rst(rst), .a(a), .d(d),
    .n_wr(n_wr), .n_m1(n_m1), .n_iorq(n_iorq),
    .n_iorqge(ge_st), .dac_l(st_l), .dac_r(st_r)
  );

  zx_sdrive_mixer #(.CHANNELS(2), .STEREO(0)) u_m2 (
    .clk(clk), .rst(rst), .a(a), .d(d),
    .n_wr(n_wr), .n_m1(n_m1), .n_iorq(n_iorq),
    .n_iorqge(ge_m2), .dac_l(m2_l), .dac_r(m2_r)
  );

  zx_sdrive_mixer #(.CHANNELS(4), .STEREO(0)) u_m4 (
    .clk(clk), .rst(rst), .a(a), .d(d),
    .n_wr(n_wr), .n_m1(n_m1), .n_iorq(n_iorq),
    .n_iorqge(ge_m4), .dac_l(m4_l), .dac_r(m4_r)
  );

  function automatic string oname(int k);
    case (k)
      0: return "st_l";
      1: return "st_r";
      2: return "m2_l";
      3: return "m2_r";
      4: return "m4_l";
      default: return "m4_r";
    endcase
  endfunction

  // expected mix for output k: 0/1 stereo 4ch, 2/3 mono 2ch, 4/5 mono 4ch
  function automatic int exp_sum(int k);
    int chans, s;
    bit stereo, left;
    chans  = (k == 2 || k == 3) ? 2 : 4;
    stereo = (k < 2);
    left   = (k % 2 == 0);
    s = 0;
    for (int n = 0; n < chans; n++)
      if (!stereo || (left ? (n < 2) : (n >= 2)))
        s += m_ch[n];
    if (m_beep != 0) s += 64;
    if (m_tape != 0) s += 32;
    if (s > 1023) s = 1023;
    return s;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 4; n++) m_ch[n] = 0;
    m_beep = 0;
    m_tape = 0;
  endtask

  task automatic model_write(input logic [7:0] ad, input logic [7:0] dv);
    if (ad[0] == 1'b0) begin
      m_beep = dv[4];
      m_tape = dv[3];
    end
    if (ad == 8'h0F || ad == 8'hFB) m_ch[0] = dv;
    if (ad == 8'h1F || ad == 8'hFB) m_ch[1] = dv;
    if (ad == 8'h4F || ad == 8'hFB) m_ch[2] = dv;
    if (ad == 8'h5F || ad == 8'hFB) m_ch[3] = dv;
  endtask

  task automatic bus_idle();
    a      = 8'h01;
    d      = 8'h00;
    n_iorq = 1'b1;
    n_wr   = 1'b1;
    n_m1   = 1'b1;
  endtask

  // I/O cycle of len clocks; data changes to dv2 after the second clock
  task automatic bus_write(input logic [7:0] ad, input logic [7:0] dv,
                           input logic [7:0] dv2, input int len,
                           input logic m1);
    @(negedge clk);
    a      = ad;
    d      = dv;
    n_iorq = 1'b0;
    n_wr   = 1'b0;
    n_m1   = m1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 1) d = dv2;
    end
    bus_idle();
    if (m1) model_write(ad, dv);
  endtask

  task automatic measure(input int n);
    repeat (8) @(negedge clk);
    for (int k = 0; k < 6; k++) cnt[k] = 0;
    repeat (n) begin
      @(negedge clk);
      cnt[0] += int'(st_l);
      cnt[1] += int'(st_r);
      cnt[2] += int'(m2_l);
      cnt[3] += int'(m2_r);
      cnt[4] += int'(m4_l);
      cnt[5] += int'(m4_r);
    end
  endtask

  task automatic test_reset();
    bus_idle();
    a   = 8'h00;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    tests++;
    if (ge_st !== 1'b0 || ge_m2 !== 1'b0 || ge_m4 !== 1'b0) begin
      fails++;
      $display("FAIL reset_ge: got %b%b%b want 000 (z pulled low)",
               ge_st, ge_m2, ge_m4);
    end
    measure(2048);
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (cnt[k] != 0) begin
        fails++;
        $display("FAIL reset_zero %s: ones=%0d want 0", oname(k), cnt[k]);
      end
    end
  endtask

  task automatic test_single_commit();
    bus_write(8'h0F, 8'hA5, 8'h5A, 6, 1'b1);
    measure(1024);
    for (int k = 0; k < 6; k++) begin
      int e, df;
      e  = exp_sum(k);
      df = cnt[k] - e;
      tests++;
      if ((e == 0 && cnt[k] != 0) || df > 1 || df < -1) begin
        fails++;
        $display("FAIL single_commit %s: ones=%0d want %0d+/-1",
                 oname(k), cnt[k], e);
      end
    end
  endtask

  // covox broadcast, then full-scale cases around the clamp
  task automatic test_covox_sat();
    logic [7:0] ads [4] = '{8'hFB, 8'hFB, 8'hFE, 8'hFE};
    logic [7:0] dvs [4] = '{8'h80, 8'hFF, 8'h18, 8'h10};
    for (int t = 0; t < 4; t++) begin
      bus_write(ads[t], dvs[t], dvs[t], 3, 1'b1);
      measure(1024);
      for (int k = 0; k < 6; k++) begin
        int e, df;
        e  = exp_sum(k);
        df = cnt[k] - e;
        tests++;
        if ((e == 0 && cnt[k] != 0) || df > 1 || df < -1) begin
          fails++;
          $display("FAIL covox_sat%0d %s: ones=%0d want %0d+/-1",
                   t, oname(k), cnt[k], e);
        end
      end
    end
  endtask

  task automatic test_iorqge();
    logic [7:0] ads [9] = '{8'h00, 8'h4F, 8'h0F, 8'h1F, 8'h5F,
                            8'hFB, 8'hFE, 8'h4E, 8'h0F};
    logic [2:0] pv;
    logic [2:0] ev;
    logic [2:0] gv;
    pv = 3'b000;
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      a = ads[t];
      ev[2] = (a == 8'h0F || a == 8'h1F || a == 8'h4F ||
               a == 8'h5F || a == 8'hFB);
      ev[1] = (a == 8'h0F || a == 8'h1F || a == 8'hFB);
      ev[0] = ev[2];
      #1;
      gv = {ge_st, ge_m2, ge_m4};
      tests++;
      if (gv !== pv) begin
        fails++;
        $display("FAIL iorqge_pre a=%h: got %b want %b", a, gv, pv);
      end
      @(negedge clk);
      gv = {ge_st, ge_m2, ge_m4};
      tests++;
      if (gv !== ev) begin
        fails++;
        $display("FAIL iorqge a=%h: got %b want %b", a, gv, ev);
      end
      pv = ev;
    end
    bus_idle();
  endtask

  task automatic test_m1_ignored();
    bus_write(8'hFB, 8'h00, 8'h00, 4, 1'b0);
    bus_write(8'h1E, 8'h10, 8'h10, 4, 1'b0);
    measure(1024);
    for (int k = 0; k < 6; k++) begin
      int e, df;
      e  = exp_sum(k);
      df = cnt[k] - e;
      tests++;
      if ((e == 0 && cnt[k] != 0) || df > 1 || df < -1) begin
        fails++;
        $display("FAIL m1_ignored %s: ones=%0d want %0d+/-1",
                 oname(k), cnt[k], e);
      end
    end
  endtask

  task automatic test_rst_mid_write();
    int ones;
    @(negedge clk);
    a      = 8'h1F;
    d      = 8'h3C;
    n_iorq = 1'b0;
    n_wr   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    ones = 0;
    repeat (4) begin
      @(negedge clk);
      ones += int'(st_l) + int'(st_r) + int'(m2_l) + int'(m2_r)
            + int'(m4_l) + int'(m4_r);
    end
    tests++;
    if (ones != 0) begin
      fails++;
      $display("FAIL rst_hold: ones=%0d want 0", ones);
    end
    model_reset();
    model_write(8'h1F, 8'h3C);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    d = 8'h55;
    repeat (3) @(negedge clk);
    bus_idle();
    measure(1024);
    for (int k = 0; k < 6; k++) begin
      int e, df;
      e  = exp_sum(k);
      df = cnt[k] - e;
      tests++;
      if ((e == 0 && cnt[k] != 0) || df > 1 || df < -1) begin
        fails++;
        $display("FAIL rst_mid_write %s: ones=%0d want %0d+/-1",
                 oname(k), cnt[k], e);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] plist [8] = '{8'h0F, 8'h1F, 8'h4F, 8'h5F,
                              8'hFB, 8'hFE, 8'h10, 8'h01};
    for (int r = 0; r < 8; r++) begin
      int nw;
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        logic [7:0] ad, dv, dv2;
        ad  = plist[$urandom_range(0, 7)];
        dv  = 8'($urandom_range(0, 255));
        dv2 = 8'($urandom_range(0, 255));
        bus_write(ad, dv, dv2, $urandom_range(1, 5), 1'b1);
      end
      measure(1024);
      for (int k = 0; k < 6; k++) begin
        int e, df;
        e  = exp_sum(k);
        df = cnt[k] - e;
        tests++;
        if ((e == 0 && cnt[k] != 0) || df > 1 || df < -1) begin
          fails++;
          $display("FAIL random%0d %s: ones=%0d want %0d+/-1",
                   r, oname(k), cnt[k], e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bus_write(8'h0F, 8'h21, 8'hEE, 2, 1'b1);
    bus_write(8'h1F, 8'h43, 8'hEE, 1, 1'b1);
    bus_write(8'h5F, 8'h65, 8'hEE, 3, 1'b1);
    bus_write(8'hFE, 8'h08, 8'h10, 3, 1'b1);
    measure(1024);
    for (int k = 0; k < 6; k++) begin
      int e, df;
      e  = exp_sum(k);
      df = cnt[k] - e;
      tests++;
      if ((e == 0 && cnt[k] != 0) || df > 1 || df < -1) begin
        fails++;
        $display("FAIL back_to_back %s: ones=%0d want %0d+/-1",
                 oname(k), cnt[k], e);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_idle();
    model_reset();
    test_reset();
    test_single_commit();
    test_covox_sat();
    test_iorqge();
    test_m1_ignored();
    test_rst_mid_write();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
